// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit path: serializer state type, default
// word width, and the 1011 sequence detector's state constants.
package seq_pkg;

    localparam int SER_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Detector states count how much of the 1011 pattern has been matched.
    localparam logic [2:0] DET_S0      = 3'd0;
    localparam logic [2:0] DET_S1      = 3'd1;
    localparam logic [2:0] DET_S10     = 3'd2;
    localparam logic [2:0] DET_S101    = 3'd3;
    localparam logic [2:0] DET_S1011   = 3'd4;
    localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage

// File: rtl/ser_shift_reg.sv
// Shift register and bit counter for the serializer; the head bit is the one
// currently presented on the serial output.
module ser_shift_reg
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic [WIDTH-1:0] sh,
    output logic [CNT_W-1:0] cnt,
    output logic             head_bit,
    output logic             at_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sh_shifted_s;

    // Move the register one place toward the output end, filling with zero.
    always_comb begin
        sh_shifted_s = sh_r;
        if (MSB_FIRST) begin
            sh_shifted_s = {sh_r[WIDTH-2:0], 1'b0};
        end else begin
            sh_shifted_s = {1'b0, sh_r[WIDTH-1:1]};
        end
    end

    // Load wins over shift; with neither, sh and cnt hold (stall case).
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r  <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            sh_r  <= load_data;
            cnt_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            sh_r  <= sh_shifted_s;
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            sh_r  <= sh_r;
            cnt_r <= cnt_r;
        end
    end

    assign sh       = sh_r;
    assign cnt      = cnt_r;
    assign head_bit = MSB_FIRST ? sh_r[WIDTH-1] : sh_r[0];
    assign at_last  = (cnt_r == LAST_CNT);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so that consecutive
// words stream without a gap; in_ready is registered and independent of out_ready.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_t       state_r;
    ser_state_t       state_next_s;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic             hold_full_next_s;
    logic             hold_we_s;
    logic             hold_clr_s;
    logic             in_ready_r;
    logic             busy_r;

    logic             accept_s;
    logic             consume_s;
    logic             load_s;
    logic [WIDTH-1:0] load_data_s;
    logic             shift_s;
    logic [WIDTH-1:0] sh_s;
    logic [CNT_W-1:0] cnt_s;
    logic             head_bit_s;
    logic             at_last_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = (state_r == SHIFT) & out_ready;

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_data (load_data_s),
        .shift     (shift_s),
        .sh        (sh_s),
        .cnt       (cnt_s),
        .head_bit  (head_bit_s),
        .at_last   (at_last_s)
    );

    // Next state plus shift-register and hold-register controls.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_data_s  = in_data;
        shift_s      = 1'b0;
        hold_we_s    = 1'b0;
        hold_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s       = 1'b1;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (consume_s && !at_last_s) begin
                    shift_s = 1'b1;
                end else if (consume_s && hold_full_r) begin
                    load_s      = 1'b1;
                    load_data_s = hold_r;
                    hold_clr_s  = 1'b1;
                end else if (consume_s && accept_s) begin
                    load_s = 1'b1;
                end else if (consume_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
                // An accept never coincides with a full hold, since in_ready is low then.
                if (accept_s && !(consume_s && at_last_s)) begin
                    hold_we_s = 1'b1;
                end else begin
                    hold_we_s = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Hold-flag next value, shared by the flag register and in_ready.
    always_comb begin
        hold_full_next_s = hold_full_r;
        if (hold_clr_s) begin
            hold_full_next_s = 1'b0;
        end else if (hold_we_s) begin
            hold_full_next_s = 1'b1;
        end else begin
            hold_full_next_s = hold_full_r;
        end
    end

    // State, hold buffer and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hold_r      <= hold_we_s ? in_data : hold_r;
            hold_full_r <= hold_full_next_s;
            in_ready_r  <= ~hold_full_next_s;
            busy_r      <= (state_next_s == SHIFT) | hold_full_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = (state_r == SHIFT);
    assign out_bit   = out_valid & head_bit_s;
    assign out_last  = out_valid & at_last_s;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one stimulus
// stream; a word-level model predicts every output each cycle.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic m_in_ready, m_out_bit, m_out_valid, m_out_last, m_busy;
    logic l_in_ready, l_out_bit, l_out_valid, l_out_last, l_busy;

    int tests = 0;
    int fails = 0;

    // Pending bits in output order: {bit, is_last_of_word}.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    bit started = 1'b0;
    bit rst_q = 1'b1;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_in_ready), .out_bit(m_out_bit), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .busy(l_busy)
    );

    // Capacity is one word shifting plus one held word.
    function automatic bit exp_ready();
        return !rst_q && (q_m.size() <= W);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] w);
        logic a;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = m_in_ready;
            tick();
            if (a) return;
        end
        tests++;
        fails++;
        $display("FAIL offer_timeout: word %h not accepted within 40 cycles", w);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q_m.size() == 0) begin
                tick();
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d bits still pending", q_m.size());
        tick();
    endtask

    // Reference model: updates pending bits on each rising edge.
    initial begin : model
        bit acc;
        bit cons;
        forever begin
            @(posedge clk);
            acc  = in_valid && exp_ready();
            cons = (q_m.size() != 0) && out_ready;
            if (reset) begin
                q_m.delete();
                q_l.delete();
            end else begin
                if (cons) begin
                    void'(q_m.pop_front());
                    void'(q_l.pop_front());
                end
                if (acc) begin
                    for (int i = W - 1; i >= 0; i--) q_m.push_back({in_data[i], (i == 0) ? 1'b1 : 1'b0});
                    for (int i = 0; i < W; i++) q_l.push_back({in_data[i], (i == W - 1) ? 1'b1 : 1'b0});
                end
            end
            rst_q   = reset;
            started = 1'b1;
        end
    end

    // Monitor: compares every output against the model, away from the active edge.
    initial begin : monitor
        bit ev;
        forever begin
            @(negedge clk);
            if (started) begin
                ev = (q_m.size() != 0);
                chk("msb.out_valid", m_out_valid, ev);
                chk("msb.in_ready", m_in_ready, exp_ready());
                chk("msb.busy", m_busy, ev);
                chk("msb.out_bit", m_out_bit, ev ? q_m[0][1] : 1'b0);
                chk("msb.out_last", m_out_last, ev ? q_m[0][0] : 1'b0);
                chk("lsb.out_valid", l_out_valid, ev);
                chk("lsb.in_ready", l_in_ready, exp_ready());
                chk("lsb.busy", l_busy, ev);
                chk("lsb.out_bit", l_out_bit, ev ? q_l[0][1] : 1'b0);
                chk("lsb.out_last", l_out_last, ev ? q_l[0][0] : 1'b0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        out_ready = 1'b1;

        offer(8'hB0); in_valid = 1'b0; drain();
        offer(8'h0D); in_valid = 1'b0; drain();

        offer(8'hA5); offer(8'h3C); in_valid = 1'b0; drain();

        offer(8'hF0); in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        offer(8'h11); offer(8'h22);
        in_data = 8'h33; in_valid = 1'b1;
        repeat (4) tick();
        out_ready = 1'b1;
        offer(8'h33); in_valid = 1'b0; drain();

        out_ready = 1'b0;
        offer(8'hFF); offer(8'h81); in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        drain();

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
